// File: rtl/spi_flash_slave.sv
// Mode-0 SPI NOR-flash emulator, oversampled on the system clock, serving a preloaded byte memory.
// Commands: READ (03), JEDEC-ID (9F), READ-STATUS (05), POWER-DOWN (B9), RELEASE-POWER-DOWN (AB).
module spi_flash_slave #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flash_csb,
    input  logic                         flash_clk,
    input  logic                         flash_io0,
    output logic                         flash_io1,
    output logic                         flash_io1_oe,
    input  logic                         load_en,
    input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
    input  logic [7:0]                   load_data,
    output logic                         powered_down
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, ID, STATUS, IGNORE} state_t;

    logic [7:0]    r_mem [MEM_BYTES];

    logic          r_csb_s1, r_csb_s2;
    logic          r_clk_s1, r_clk_s2, r_clk_d;
    logic          r_io0_s1, r_io0_s2;

    state_t        r_state, w_state_nxt;
    logic [4:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic          r_io1, w_io1_nxt;
    logic          r_oe, w_oe_nxt;
    logic          r_pd, w_pd_nxt;

    logic          w_rise, w_fall;
    logic [7:0]    w_cmd;
    logic [AW-1:0] w_addr_full, w_addr_inc;
    logic [7:0]    w_id_next;

    // csb resets high so a reset never looks like the start of a transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_csb_s1 <= 1'b1;
            r_csb_s2 <= 1'b1;
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_d  <= 1'b0;
            r_io0_s1 <= 1'b0;
            r_io0_s2 <= 1'b0;
        end else begin
            r_csb_s1 <= flash_csb;
            r_csb_s2 <= r_csb_s1;
            r_clk_s1 <= flash_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_io0_s1 <= flash_io0;
            r_io0_s2 <= r_io0_s1;
        end
    end

    // NOTE: the array sits outside the reset so preloaded contents survive a reset.
    always_ff @(posedge clock) begin
        if (load_en) r_mem[load_addr] <= load_data;
    end

    assign w_rise      = r_clk_s2 & ~r_clk_d;
    assign w_fall      = ~r_clk_s2 & r_clk_d;
    assign w_cmd       = {r_shift[6:0], r_io0_s2};
    assign w_addr_full = {r_addr[AW-2:0], r_io0_s2};
    assign w_addr_inc  = r_addr + AW'(1);
    assign w_id_next   = (w_addr_inc == AW'(1)) ? JEDEC_ID[15:8] :
                         (w_addr_inc == AW'(2)) ? JEDEC_ID[7:0]  : 8'h00;

    // NOTE: every next-value gets its hold default first so no branch can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_addr_nxt    = r_addr;
        w_io1_nxt     = r_io1;
        w_oe_nxt      = r_oe;
        w_pd_nxt      = r_pd;

        if (r_csb_s2) begin
            w_state_nxt   = IDLE;
            w_oe_nxt      = 1'b0;
            w_bit_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = CMD;
                    w_bit_cnt_nxt = '0;
                    w_oe_nxt      = 1'b0;
                end
                CMD: if (w_rise) begin
                    w_shift_nxt   = w_cmd;
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd7) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = IGNORE;
                        if (w_cmd == 8'hAB) begin
                            w_pd_nxt = 1'b0;
                        end else if (!r_pd) begin
                            case (w_cmd)
                                8'h03: begin
                                    w_state_nxt = ADDR;
                                    w_addr_nxt  = '0;
                                end
                                8'h9F: begin
                                    w_state_nxt = ID;
                                    w_shift_nxt = JEDEC_ID[23:16];
                                    w_addr_nxt  = '0;
                                end
                                8'h05: begin
                                    w_state_nxt = STATUS;
                                    w_shift_nxt = 8'h00;
                                end
                                8'hB9:   w_pd_nxt = 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                // Only the low AW address bits are kept, which makes the address wrap modulo MEM_BYTES.
                ADDR: if (w_rise) begin
                    w_addr_nxt    = w_addr_full;
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd23) begin
                        w_bit_cnt_nxt = '0;
                        w_shift_nxt   = r_mem[w_addr_full];
                        w_state_nxt   = READ;
                    end
                end
                READ, ID, STATUS: if (w_fall) begin
                    w_oe_nxt      = 1'b1;
                    w_io1_nxt     = r_shift[7];
                    w_shift_nxt   = {r_shift[6:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd7) begin
                        w_bit_cnt_nxt = '0;
                        if (r_state == READ) begin
                            w_addr_nxt  = w_addr_inc;
                            w_shift_nxt = r_mem[w_addr_inc];
                        end else if (r_state == ID) begin
                            // The ID byte index saturates at 3 so the stream stays at zero.
                            w_addr_nxt  = (r_addr == AW'(3)) ? r_addr : w_addr_inc;
                            w_shift_nxt = w_id_next;
                        end else begin
                            w_shift_nxt = 8'h00;
                        end
                    end
                end
                IGNORE:  w_oe_nxt = 1'b0;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_io1     <= 1'b0;
            r_oe      <= 1'b0;
            r_pd      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_addr    <= w_addr_nxt;
            r_io1     <= w_io1_nxt;
            r_oe      <= w_oe_nxt;
            r_pd      <= w_pd_nxt;
        end
    end

    assign flash_io1    = r_io1;
    assign flash_io1_oe = r_oe;
    assign powered_down = r_pd;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Bench for spi_flash_slave: a byte-level flash model predicts the MISO bit seen at every SPI rise.
// Directed transactions pin the model with literal values; a randomized phase covers command mixes.
module tb_spi_flash_slave;
    localparam int MEM_BYTES = 1024;
    localparam int HALF      = 40;

    logic       clock = 1'b0;
    logic       reset;
    logic       flash_csb, flash_clk, flash_io0;
    logic       flash_io1, flash_io1_oe;
    logic       load_en;
    logic [9:0] load_addr;
    logic [7:0] load_data;
    logic       powered_down;

    typedef struct packed {
        logic oe;
        logic val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cmp_e;
    logic [7:0]  tx_q[$];
    logic [7:0]  m_mem [MEM_BYTES];
    logic        m_pd;
    bit          chk_en;
    logic [31:0] rx_word;
    int          n_checks, n_fail;

    spi_flash_slave #(.MEM_BYTES(MEM_BYTES), .JEDEC_ID(24'hEF4016)) dut (
        .clock        (clock),
        .reset        (reset),
        .flash_csb    (flash_csb),
        .flash_clk    (flash_clk),
        .flash_io0    (flash_io0),
        .flash_io1    (flash_io1),
        .flash_io1_oe (flash_io1_oe),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .powered_down (powered_down)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // The master samples MISO on each rising SPI edge; compare against the model there.
    always @(posedge flash_clk) begin
        if (chk_en && !flash_csb) begin
            if (exp_q.size() == 0) begin
                check("exp_underflow", 32'd1, 32'd0);
            end else begin
                cmp_e = exp_q.pop_front();
                check("io1_oe", {31'd0, flash_io1_oe}, {31'd0, cmp_e.oe});
                if (cmp_e.oe) begin
                    check("io1", {31'd0, flash_io1}, {31'd0, cmp_e.val});
                    rx_word = {rx_word[30:0], flash_io1};
                end
            end
        end
    end

    // Flash behaviour at byte level: what MISO must show at each of nbits rising edges.
    task automatic model_xfer(input int nbits);
        logic [7:0]  cmd  = tx_q[0];
        logic [23:0] a24  = {tx_q[1], tx_q[2], tx_q[3]};
        logic [23:0] jid  = 24'hEF4016;
        bit          dead = m_pd && (cmd != 8'hAB);
        int          base = int'(a24) % MEM_BYTES;
        exp_t        e;
        logic [7:0]  byt;
        int          j, idx;
        for (int r = 0; r < nbits; r++) begin
            e = '0;
            if (r >= 8 && !dead) begin
                if (cmd == 8'h03 && r >= 32) begin
                    j     = r - 32;
                    byt   = m_mem[(base + j / 8) % MEM_BYTES];
                    e.oe  = 1'b1;
                    e.val = byt[7 - j % 8];
                end else if (cmd == 8'h9F) begin
                    j     = r - 8;
                    idx   = j / 8;
                    byt   = (idx < 3) ? jid[23 - 8 * idx -: 8] : 8'h00;
                    e.oe  = 1'b1;
                    e.val = byt[7 - j % 8];
                end else if (cmd == 8'h05) begin
                    e.oe  = 1'b1;
                    e.val = 1'b0;
                end
            end
            exp_q.push_back(e);
        end
        if (nbits >= 8) begin
            if (cmd == 8'hAB)      m_pd = 1'b0;
            else if (cmd == 8'hB9) m_pd = 1'b1;
        end
    endtask

    task automatic spi_xfer(input int nbits);
        logic [7:0] b;
        rx_word = '0;
        model_xfer(nbits);
        chk_en = 1'b1;
        @(negedge clock);
        flash_csb = 1'b0;
        for (int r = 0; r < nbits; r++) begin
            if (r / 8 < tx_q.size()) begin
                b         = tx_q[r / 8];
                flash_io0 = b[7 - r % 8];
            end else begin
                flash_io0 = 1'($urandom);
            end
            #HALF flash_clk = 1'b1;
            #HALF flash_clk = 1'b0;
        end
        #HALF flash_csb = 1'b1;
        chk_en = 1'b0;
        check("exp_leftover", exp_q.size(), 32'd0);
        exp_q.delete();
        #50;
        check("oe_after_csb", {31'd0, flash_io1_oe}, 32'd0);
        check("powered_down", {31'd0, powered_down}, {31'd0, m_pd});
        #(HALF);
    endtask

    task automatic send(input logic [7:0] cmd, input logic [23:0] addr, input int nbits);
        tx_q.delete();
        tx_q.push_back(cmd);
        tx_q.push_back(addr[23:16]);
        tx_q.push_back(addr[15:8]);
        tx_q.push_back(addr[7:0]);
        spi_xfer(nbits);
    endtask

    task automatic load(input int a, input logic [7:0] d);
        @(negedge clock);
        load_en   = 1'b1;
        load_addr = a[9:0];
        load_data = d;
        @(negedge clock);
        load_en   = 1'b0;
        m_mem[a]  = d;
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rcmd;
        reset     = 1'b1;
        flash_csb = 1'b1;
        flash_clk = 1'b0;
        flash_io0 = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        chk_en    = 1'b0;
        m_pd      = 1'b0;
        n_checks  = 0;
        n_fail    = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_oe", {31'd0, flash_io1_oe}, 32'd0);
        check("reset_io1", {31'd0, flash_io1}, 32'd0);
        check("reset_pd", {31'd0, powered_down}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            #HALF flash_clk = 1'b1;
            #HALF flash_clk = 1'b0;
            check("idle_clk_oe", {31'd0, flash_io1_oe}, 32'd0);
        end

        for (int a = 0; a < MEM_BYTES; a++) load(a, 8'($urandom));
        load(0, 8'hA5);
        load(1, 8'h5A);
        load(2, 8'hFF);
        load(3, 8'h00);

        send(8'h03, 24'h000000, 64);
        check("read_stream", rx_word, 32'hA55AFF00);

        load(1023, 8'h12);
        load(0, 8'h34);
        send(8'h03, 24'h0003FF, 48);
        check("read_wrap", {16'd0, rx_word[15:0]}, 32'h00001234);
        send(8'h03, 24'h0403FF, 48);
        check("read_alias", {16'd0, rx_word[15:0]}, 32'h00001234);

        send(8'h9F, 24'h000000, 48);
        check("jedec_tail", rx_word, 32'h40160000);
        send(8'h9F, 24'h000000, 32);
        check("jedec_id", {8'd0, rx_word[23:0]}, 32'h00EF4016);
        send(8'h05, 24'hFFFFFF, 24);
        check("status", rx_word, 32'h00000000);

        send(8'hB9, 24'h000000, 8);
        check("pd_set", {31'd0, powered_down}, 32'd1);
        send(8'h03, 24'h000000, 48);
        send(8'h9F, 24'h000000, 32);
        check("pd_held", {31'd0, powered_down}, 32'd1);
        send(8'hAB, 24'h000000, 8);
        check("pd_clear", {31'd0, powered_down}, 32'd0);
        send(8'h03, 24'h000000, 40);
        check("read_after_wake", {24'd0, rx_word[7:0]}, 32'h00000034);

        send(8'h03, 24'h000000, 20);
        send(8'h03, 24'h000001, 40);
        check("read_after_abort", {24'd0, rx_word[7:0]}, 32'h0000005A);

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, MEM_BYTES - 1)), 8'($urandom));
            case ($urandom_range(0, 7))
                0, 1, 2: rcmd = 8'h03;
                3:       rcmd = 8'h9F;
                4:       rcmd = 8'h05;
                5:       rcmd = 8'hB9;
                6:       rcmd = 8'hAB;
                default: rcmd = 8'($urandom);
            endcase
            send(rcmd, 24'($urandom), int'($urandom_range(1, 56)));
        end

        send(8'hAB, 24'h000000, 8);
        @(negedge clock);
        flash_csb = 1'b0;
        for (int r = 0; r < 40; r++) begin
            flash_io0 = (r == 6 || r == 7) ? 1'b1 : 1'b0;
            #HALF flash_clk = 1'b1;
            #HALF flash_clk = 1'b0;
        end
        #HALF;
        check("mid_read_oe", {31'd0, flash_io1_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_read_oe", {31'd0, flash_io1_oe}, 32'd0);
        check("reset_mid_read_io1", {31'd0, flash_io1}, 32'd0);
        #20 flash_csb = 1'b1;
        #20 reset = 1'b0;
        m_pd = 1'b0;
        #(HALF * 2);
        send(8'h03, 24'h000002, 40);
        check("mem_kept_over_reset", {24'd0, rx_word[7:0]}, 32'h000000FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_slave.md
Name: spi_flash_slave

Overview:
- Synthesizable single-bit SPI NOR-flash emulator. It serves a byte-addressed memory to the management SoC's flash interface (csb/clk/io0/io1) during boot.
- It runs on the system clock and oversamples the SPI pins.
- The memory array is preloaded through a parallel load port.
- It supports READ, JEDEC-ID, READ-STATUS, POWER-DOWN and RELEASE-POWER-DOWN.

Parameters:
- MEM_BYTES, 1024, memory depth in bytes; must be a power of two.
- JEDEC_ID, 24'hEF4016, 3-byte ID returned by command 0x9F, MSB byte first.

Ports:
- clock  in  1  system clock; must be at least 8x the SPI clock frequency.
- reset  in  1  asynchronous, active-high reset.
- flash_csb  in  1  SPI chip select, active low.
- flash_clk  in  1  SPI clock, mode 0.
- flash_io0  in  1  MOSI.
- flash_io1  out  1  MISO data.
- flash_io1_oe  out  1  MISO output enable.
- load_en  in  1  memory write strobe.
- load_addr  in  $clog2(MEM_BYTES)  write byte address.
- load_data  in  8  write byte.
- powered_down  out  1  power-down status.

Behaviour:
- Reset (async, active-high):
  - flash_io1=0, flash_io1_oe=0, powered_down=0.
  - FSM goes to IDLE; bit counter, shift register and address clear.
  - Memory contents are not cleared.
- Input sync:
  - csb, clk and io0 each pass through a 2-flop synchronizer; csb syncs to 1 on reset.
  - SPI clock rise/fall are detected from the synchronized clk delayed by one more flop.
- Sampling and driving (mode 0):
  - io0 is sampled on detected clk rise, MSB first.
  - io1 is updated on detected clk fall.
  - Update latency is at most 4 system clocks after the pin edge.
- FSM states: IDLE, CMD, ADDR, READ, ID, STATUS, IGNORE.
- IDLE → CMD:
  - Entered when synchronized csb goes low.
  - Bit counter is 0 and io1_oe=0.
- CMD: after 8 rising edges, decode the command byte.
  - 0x03 → ADDR.
  - 0x9F → ID, if not powered down.
  - 0x05 → STATUS, if not powered down.
  - 0xB9 → sets powered_down=1 at the 8th rise, then IGNORE.
  - 0xAB → clears powered_down at the 8th rise, then IGNORE.
  - Any other byte → IGNORE.
  - While powered_down=1, every command except 0xAB goes to IGNORE.
- ADDR:
  - Shifts in 24 address bits, MSB first.
  - The address is taken modulo MEM_BYTES.
  - After the 24th rise: fetch mem[addr] into the output shift register and go to READ.
- READ:
  - On each falling edge: io1_oe=1 and io1 = shift[7], then shift left.
  - After 8 bits output, addr increments and the next byte is loaded.
  - The address wraps from MEM_BYTES-1 to 0.
  - Streaming continues until csb rises.
- ID: streams the 3 JEDEC_ID bytes, MSB first, then outputs 0 bits.
- STATUS: repeatedly outputs 8'h00.
- IGNORE: io1_oe=0; waits for csb high.
- csb rises mid-transaction:
  - Immediate return to IDLE.
  - io1_oe=0 on the next system clock.
  - Partial bytes are discarded; powered_down keeps its value.
- Load port:
  - load_en writes mem[load_addr] on the clock edge.
  - A load has priority and is accepted in any state.
  - A byte already moved into the output shift register is not affected.
  - Later fetches see the new data.
- io1 holds its last value while io1_oe=0.

Test Plan:
- Reset then idle → io1_oe=0, io1=0, powered_down=0; csb high with the clock toggling produces no output.
- Load mem[0..3]=A5,5A,FF,00; send 03 000000 and clock 32 bits → io1 stream A5 5A FF 00, MSB first; first bit valid on the first falling edge after the 32nd rise.
- MEM_BYTES=1024: load mem[1023]=12 and mem[0]=34; read at 0x0003FF for 16 bits → 12 then 34 (wrap). Address 0x0403FF aliases to 0x3FF.
- Send 9F and clock 24 bits → EF 40 16. Send 05 → 00.
- Send B9, raise csb → powered_down=1. Then 03 000000 → io1_oe stays 0. Send AB → powered_down=0. A following read returns data.
- Raise csb after 12 address bits, then a fresh 03 000001 read → returns mem[1], no stale state. Assert reset mid-READ → io1_oe=0 immediately.
